ifetch: RTL and testbench

Instruction fetch stage with integrated IF/ID pipeline register for the pipelined MIPS core. Holds the PC, issues word fetches to instruction memory over a req/ready handshake, and presents the fetched instruction and PC+4 to decode; `instr[15:0]` drives the immediate input of the decode-stage sign extender. Supports decode stalls, pipeline flush, and branch/jump redirects. No delay slot.

---
 rtl/mips_pkg.sv | 15 +
 rtl/ifetch_npc.sv | 27 ++
 rtl/ifetch.sv | 116 +++++++++++
 tb/tb_ifetch.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core front end.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetchState_t;

endpackage

// File: rtl/ifetch_npc.sv
// Next-PC select: sequential pc+4 or a word-aligned branch/jump target.
module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jumpTaken,
  input  logic [31:0] jumpTarget,
  output logic [31:0] pcPlus4,
  output logic        redirect,
  output logic [31:0] nextPc
);

  always_comb begin
    pcPlus4  = pc + 32'd4;
    redirect = branchTaken | jumpTaken;
    // The branch belongs to the older instruction, so it wins over a jump.
    if (branchTaken)
      nextPc = branchTarget & WORD_MASK;
    else if (jumpTaken)
      nextPc = jumpTarget & WORD_MASK;
    else
      nextPc = pcPlus4;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage with IF/ID register: PC, imem handshake,
// stall/flush handling and branch/jump redirect.
module ifetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemRdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jumpTaken,
  input  logic [31:0] jumpTarget,
  output logic [31:0] instr,
  output logic [31:0] pcPlus4,
  output logic        instrValid
);

  fetchState_t state;
  logic [31:0] pc;
  logic [31:0] hold;
  logic [31:0] drainAddr;
  logic [31:0] seqPc;
  logic [31:0] nextPc;
  logic        redirect;
  logic        squash;

  npc uNpc (
    .pc          (pc),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .jumpTaken   (jumpTaken),
    .jumpTarget  (jumpTarget),
    .pcPlus4     (seqPc),
    .redirect    (redirect),
    .nextPc      (nextPc)
  );

  assign squash   = flush | redirect;
  assign imemReq  = (state == REQ) || (state == DRAIN);
  assign imemAddr = (state == DRAIN) ? drainAddr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      hold       <= '0;
      drainAddr  <= '0;
      instr      <= NOP;
      pcPlus4    <= '0;
      instrValid <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= REQ;

        REQ: begin
          if (redirect) begin
            pc <= nextPc;
            if (!imemReady) begin
              drainAddr <= pc;
              state     <= DRAIN;
            end
          end else if (imemReady) begin
            pc <= seqPc;
            // A flushed fetch is dropped; only a stalled, unflushed word is parked.
            if (!flush && stall) begin
              hold  <= imemRdata;
              state <= HOLD;
            end
          end
          if (squash || (!stall && !imemReady)) begin
            instr      <= NOP;
            instrValid <= 1'b0;
          end else if (!stall) begin
            instr      <= imemRdata;
            pcPlus4    <= seqPc;
            instrValid <= 1'b1;
          end
        end

        DRAIN: begin
          if (redirect) pc <= nextPc;
          if (imemReady) state <= REQ;
          if (squash || !stall) begin
            instr      <= NOP;
            instrValid <= 1'b0;
          end
        end

        HOLD: begin
          if (squash) begin
            if (redirect) pc <= nextPc;
            instr      <= NOP;
            instrValid <= 1'b0;
            state      <= REQ;
          end else if (!stall) begin
            // pc already advanced past the held word, so it is that word's PC+4.
            instr      <= hold;
            pcPlus4    <= pc;
            instrValid <= 1'b1;
            state      <= REQ;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch against a fetch-stream reference model.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic        stall, flush, branchTaken, jumpTaken;
  logic [31:0] branchTarget, jumpTarget;
  logic [31:0] instr, pcPlus4;
  logic        instrValid;

  int unsigned nVec = 0;
  int unsigned nErr = 0;

  // Reference model: fetch pointer, optional abandoned access, optional parked word, IF/ID.
  bit          mStarted;
  logic [31:0] mPc;
  bit          mDraining;
  logic [31:0] mDrainAddr;
  bit          mHasBuf;
  logic [31:0] mBuf;
  bit          mValid;
  logic [31:0] mInstr, mPcPlus4;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_1234;
  endfunction

  assign imemRdata = imemReady ? word(imemAddr) : 32'hDEAD_BEEF;

  ifetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemReady(imemReady), .imemRdata(imemRdata),
    .stall(stall), .flush(flush),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jumpTaken(jumpTaken), .jumpTarget(jumpTarget),
    .instr(instr), .pcPlus4(pcPlus4), .instrValid(instrValid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mStarted = 0; mPc = 32'h3000; mDraining = 0; mDrainAddr = '0;
    mHasBuf = 0; mBuf = '0; mValid = 0; mInstr = '0; mPcPlus4 = '0;
  endtask

  task automatic bubble();
    mValid = 0; mInstr = '0;
  endtask

  // Compare outputs for the current cycle, then apply inputs for the next edge.
  task automatic step(input bit rdy, input bit st, input bit fl,
                      input bit br, input logic [31:0] bt,
                      input bit jp, input logic [31:0] jt);
    bit          expReq, rd, kill;
    logic [31:0] tgt, w;
    expReq = mStarted && !mHasBuf;
    chk("imemReq", {31'b0, imemReq}, {31'b0, expReq});
    if (expReq) chk("imemAddr", imemAddr, mDraining ? mDrainAddr : mPc);
    chk("instrValid", {31'b0, instrValid}, {31'b0, mValid});
    chk("instr", instr, mInstr);
    chk("pcPlus4", pcPlus4, mPcPlus4);

    imemReady = rdy; stall = st; flush = fl;
    branchTaken = br; branchTarget = bt; jumpTaken = jp; jumpTarget = jt;

    rd   = br || jp;
    tgt  = (br ? bt : jt) & 32'hFFFF_FFFC;
    kill = fl || rd;
    if (!mStarted) begin
      mStarted = 1;
    end else if (mHasBuf) begin
      if (kill) begin
        mHasBuf = 0; if (rd) mPc = tgt; bubble();
      end else if (!st) begin
        mHasBuf = 0; mValid = 1; mInstr = mBuf; mPcPlus4 = mPc;
      end
    end else if (mDraining) begin
      if (rd) mPc = tgt;
      if (rdy) mDraining = 0;
      if (kill || !st) bubble();
    end else if (rd) begin
      if (!rdy) begin mDraining = 1; mDrainAddr = mPc; end
      mPc = tgt;
      bubble();
    end else if (rdy) begin
      w = word(mPc);
      mPc = mPc + 32'd4;
      if (fl) bubble();
      else if (!st) begin mValid = 1; mInstr = w; mPcPlus4 = mPc; end
      else begin mHasBuf = 1; mBuf = w; end
    end else if (fl || !st) begin
      bubble();
    end
    @(negedge clk);
  endtask

  task automatic plain(input bit rdy, input bit st);
    step(rdy, st, 0, 0, '0, 0, '0);
  endtask

  function automatic logic [31:0] randTarget();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'h3000 + 32'($urandom_range(0, 1023));
  endfunction

  initial begin
    rst_n = 1'b0;
    imemReady = 0; stall = 0; flush = 0;
    branchTaken = 0; jumpTaken = 0; branchTarget = '0; jumpTarget = '0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait streaming from reset
    repeat (5) plain(1, 0);
    // Stall across a ready fetch, then release
    repeat (3) plain(1, 1);
    repeat (3) plain(1, 0);
    // Branch during a wait state: old access drains first
    plain(0, 0);
    step(0, 0, 0, 1, 32'h3101, 0, '0);
    plain(0, 0);
    repeat (3) plain(1, 0);
    // Branch and jump together
    step(1, 0, 0, 1, 32'h3200, 1, 32'h3400);
    repeat (2) plain(1, 0);
    // Flush with stall
    step(1, 1, 1, 0, '0, 0, '0);
    repeat (2) plain(1, 0);
    // PC wrap at the top of the address space
    step(1, 0, 0, 0, '0, 1, 32'hFFFF_FFFC);
    repeat (3) plain(1, 0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 11) == 0, randTarget(),
           $urandom_range(0, 11) == 0, randTarget());

    // Reset asserted in the middle of a wait state
    plain(0, 0);
    plain(0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstReq", {31'b0, imemReq}, 32'h0);
    chk("rstValid", {31'b0, instrValid}, 32'h0);
    chk("rstInstr", instr, 32'h0);
    chk("rstPcPlus4", pcPlus4, 32'h0);
    imemReady = 0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) plain(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
